// File: rtl/led_scanner.sv
// rtl/led_scanner.sv - LED scan-pattern generator (bounce/rotate/bar); optional fading trail via LED_SCANNER_TRAIL_EN
module led_scanner #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24,
  parameter int IW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] step_div,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             dir,
  output logic [IW-1:0]    pos_idx
);

  localparam logic [1:0] MODE_BOUNCE = 2'd0;
  localparam logic [1:0] MODE_ROT_L  = 2'd1;
  localparam logic [1:0] MODE_ROT_R  = 2'd2;
  localparam logic [1:0] MODE_BAR    = 2'd3;

  localparam logic [WIDTH-1:0] POS_INIT = WIDTH'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [IW-1:0]    lvl_q, lvl_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic [1:0]       mode_q, mode_d;
  logic             mode_chg;

  assign mode_chg = (mode != mode_q);

  // Next-state: a mode change re-initialises and suppresses the tick; otherwise the prescaler drives pattern steps.
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    lvl_d  = lvl_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    mode_d = mode_q;
    if (mode_chg) begin
      mode_d = mode;
      cnt_d  = '0;
      pos_d  = POS_INIT;
      lvl_d  = '0;
      dir_d  = 1'b0;
    end else if (run) begin
      // >= rather than == so a step_div lowered below cnt still ticks next cycle
      if (cnt_q >= step_div) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        case (mode_q)
          MODE_BOUNCE: begin
            if (!dir_q) begin
              if (pos_q[WIDTH-1]) begin
                pos_d = pos_q >> 1;
                dir_d = 1'b1;
              end else begin
                pos_d = pos_q << 1;
              end
            end else begin
              if (pos_q[0]) begin
                pos_d = pos_q << 1;
                dir_d = 1'b0;
              end else begin
                pos_d = pos_q >> 1;
              end
            end
          end
          MODE_ROT_L: begin
            pos_d = {pos_q[WIDTH-2:0], pos_q[WIDTH-1]};
            dir_d = 1'b0;
          end
          MODE_ROT_R: begin
            pos_d = {pos_q[0], pos_q[WIDTH-1:1]};
            dir_d = 1'b1;
          end
          default: begin
            if (!dir_q) begin
              lvl_d = lvl_q + 1'b1;
              if (lvl_q == IW'(WIDTH - 1)) dir_d = 1'b1;
            end else begin
              lvl_d = lvl_q - 1'b1;
              if (lvl_q == IW'(1)) dir_d = 1'b0;
            end
          end
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pattern and prescaler state; reset also adopts the current mode so no spurious re-init follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pos_q  <= POS_INIT;
      lvl_q  <= '0;
      dir_q  <= 1'b0;
      tick_q <= 1'b0;
      mode_q <= mode;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      lvl_q  <= lvl_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
      mode_q <= mode_d;
    end
  end

`ifdef LED_SCANNER_TRAIL_EN
  logic [WIDTH-1:0] h1_q, h2_q;
  logic [1:0]       pwm_q;

  // Trail history follows the head one and two steps behind; pwm free-runs to dim the trail.
  always_ff @(posedge clk) begin
    if (rst) begin
      h1_q  <= '0;
      h2_q  <= '0;
      pwm_q <= 2'd0;
    end else begin
      pwm_q <= pwm_q + 2'd1;
      if (mode_chg) begin
        h1_q <= '0;
        h2_q <= '0;
      end else if (tick_d) begin
        h2_q <= h1_q;
        h1_q <= pos_q;
      end
    end
  end
`endif

  // LED decode from registers only: thermometer bar in mode 3, head (plus dimmed trail when built) otherwise.
  always_comb begin
    led = '0;
    if (mode_q == MODE_BAR) begin
      for (int i = 0; i < WIDTH; i++) begin
        led[i] = (lvl_q > IW'(i));
      end
    end else begin
`ifdef LED_SCANNER_TRAIL_EN
      led = pos_q | (h1_q & {WIDTH{~pwm_q[0]}}) | (h2_q & {WIDTH{pwm_q == 2'd0}});
`else
      led = pos_q;
`endif
    end
  end

  // Head index is the position of the single set bit of pos; bar mode reports the level instead.
  always_comb begin
    pos_idx = '0;
    if (mode_q == MODE_BAR) begin
      pos_idx = lvl_q;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pos_q[i]) pos_idx = IW'(i);
      end
    end
  end

  assign tick = tick_q;
  // Rotate-right always reports movement toward LSB, even before its first step.
  assign dir  = dir_q | (mode_q == MODE_ROT_R);

endmodule

// File: tb/tb_led_scanner.sv
// tb/tb_led_scanner.sv - randomized self-checking bench for led_scanner against an arithmetic pattern model
module tb_led_scanner;
  localparam int W   = 8;
  localparam int DW  = 24;
  localparam int IWB = $clog2(W + 1);

  typedef logic [W+IWB+1:0] vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            run = 1'b0;
  logic [DW-1:0]   step_div = '0;
  logic [1:0]      mode = 2'd0;
  logic [W-1:0]    led;
  logic            tick;
  logic            dir;
  logic [IWB-1:0]  pos_idx;

  int checks = 0;
  int errors = 0;

  // model state: clocks since last step, steps since re-init, pwm phase
  int       m_cnt = 0;
  int       m_k = 0;
  int       m_pwm = 0;
  logic [1:0] m_mode = 2'd0;
  logic     m_tick = 1'b0;

  led_scanner #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .run(run), .step_div(step_div), .mode(mode),
    .led(led), .tick(tick), .dir(dir), .pos_idx(pos_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // head index (modes 0-2) or bar level (mode 3) after k steps
  function automatic int head_idx(input logic [1:0] md, input int k);
    int p;
    case (md)
      2'd0: begin p = k % (2*(W-1)); return (p < W) ? p : 2*(W-1) - p; end
      2'd1: return k % W;
      2'd2: return (W - (k % W)) % W;
      default: begin p = k % (2*W); return (p <= W) ? p : 2*W - p; end
    endcase
  endfunction

  function automatic logic exp_dir(input logic [1:0] md, input int k);
    int p;
    case (md)
      2'd0: begin p = k % (2*(W-1)); return (k > 0) && (p == 0 || p >= W); end
      2'd1: return 1'b0;
      2'd2: return 1'b1;
      default: return (k % (2*W)) >= W;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_led(input logic [1:0] md, input int k);
    logic [W-1:0] v;
    v = '0;
    if (md == 2'd3) begin
      for (int i = 0; i < head_idx(md, k); i++) v[i] = 1'b1;
      return v;
    end
    v[head_idx(md, k)] = 1'b1;
`ifdef LED_SCANNER_TRAIL_EN
    if (k >= 1 && (m_pwm % 2) == 0) v[head_idx(md, k-1)] = 1'b1;
    if (k >= 2 && m_pwm == 0)       v[head_idx(md, k-2)] = 1'b1;
`endif
    return v;
  endfunction

  function automatic vec_t exp_vec();
    return {m_tick, exp_dir(m_mode, m_k), IWB'(head_idx(m_mode, m_k)), exp_led(m_mode, m_k)};
  endfunction

  // one clock: advance the model from the inputs seen at the edge, then settle
  task automatic cycle();
    @(posedge clk);
    m_tick = 1'b0;
    if (rst) begin
      m_cnt = 0; m_k = 0; m_mode = mode; m_pwm = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 4;
      if (mode != m_mode) begin
        m_cnt = 0; m_k = 0; m_mode = mode;
      end else if (run) begin
        if (m_cnt >= int'(step_div)) begin
          m_tick = 1'b1; m_cnt = 0; m_k++;
        end else begin
          m_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset(input logic [1:0] md);
    rst = 1'b1; run = 1'b0; mode = md;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step_div = 3;
    do_reset(2'd0);
    checks++;
    if ({tick, dir, pos_idx, led} !== {1'b0, 1'b0, IWB'(0), W'(1)}) begin
      errors++;
      $display("FAIL reset_mode0: got tick=%b dir=%b idx=%0d led=%h, expected 0 0 0 01", tick, dir, pos_idx, led);
    end
    do_reset(2'd3);
    checks++;
    if ({tick, dir, pos_idx, led} !== {1'b0, 1'b0, IWB'(0), W'(0)}) begin
      errors++;
      $display("FAIL reset_mode3: got tick=%b dir=%b idx=%0d led=%h, expected 0 0 0 00", tick, dir, pos_idx, led);
    end
  endtask

  task automatic test_bounce();
    int first = -1;
    do_reset(2'd0);
    step_div = 3; run = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      cycle();
      if (tick === 1'b1 && first < 0) first = c;
      checks++;
      if ({tick, dir, pos_idx, led} !== exp_vec()) begin
        errors++;
        $display("FAIL bounce c=%0d: got %h expected %h", c, {tick, dir, pos_idx, led}, exp_vec());
      end
      if (m_tick && (m_k == 7 || m_k == 8 || m_k == 14)) begin
        checks++;
        if ({dir, pos_idx} !== ((m_k == 7) ? {1'b0, IWB'(7)} : (m_k == 8) ? {1'b1, IWB'(6)} : {1'b1, IWB'(0)})) begin
          errors++;
          $display("FAIL bounce_turn k=%0d: got dir=%b idx=%0d", m_k, dir, pos_idx);
        end
      end
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL bounce_first_tick: got clock %0d expected 4", first);
    end
  endtask

  task automatic test_rotate();
    do_reset(2'd1);
    step_div = DW'($urandom_range(0, 2)); run = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      checks++;
      if ({tick, dir, pos_idx, led} !== exp_vec()) begin
        errors++;
        $display("FAIL rotl c=%0d: got %h expected %h", c, {tick, dir, pos_idx, led}, exp_vec());
      end
      if (m_tick && m_k == 8) begin
        checks++;
        if (pos_idx !== IWB'(0)) begin
          errors++;
          $display("FAIL rotl_wrap: got idx=%0d expected 0", pos_idx);
        end
      end
    end
    do_reset(2'd2);
    step_div = 0; run = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      checks++;
      if ({tick, dir, pos_idx, led} !== exp_vec()) begin
        errors++;
        $display("FAIL rotr c=%0d: got %h expected %h", c, {tick, dir, pos_idx, led}, exp_vec());
      end
      if (c < 2) begin
        checks++;
        if (pos_idx !== ((c == 0) ? IWB'(7) : IWB'(6)) || dir !== 1'b1) begin
          errors++;
          $display("FAIL rotr_seq c=%0d: got idx=%0d dir=%b", c, pos_idx, dir);
        end
      end
    end
  endtask

  task automatic test_bar();
    do_reset(2'd3);
    step_div = 0; run = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      checks++;
      if ({tick, dir, pos_idx, led} !== exp_vec()) begin
        errors++;
        $display("FAIL bar c=%0d: got %h expected %h", c, {tick, dir, pos_idx, led}, exp_vec());
      end
      if (m_k == 8 || m_k == 9) begin
        checks++;
        if ({dir, led} !== ((m_k == 8) ? {1'b1, W'(8'hFF)} : {1'b1, W'(8'h7F)})) begin
          errors++;
          $display("FAIL bar_top k=%0d: got dir=%b led=%h", m_k, dir, led);
        end
      end
    end
  endtask

  task automatic test_run_pause();
    logic [IWB-1:0] held;
    int n;
    bit found = 0;
    do_reset(2'd0);
    step_div = 3; run = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle();
      if (m_cnt == 2 && m_k >= 2) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL pause_setup: cnt=2 not reached");
    end
    held = pos_idx;
    run = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      checks++;
      if ({tick, pos_idx} !== {1'b0, held} || {tick, dir, pos_idx, led} !== exp_vec()) begin
        errors++;
        $display("FAIL pause_frozen c=%0d: got tick=%b idx=%0d led=%h expected idx=%0d", c, tick, pos_idx, led, held);
      end
    end
    run = 1'b1;
    n = 0;
    for (int c = 1; c <= 10 && n == 0; c++) begin
      cycle();
      if (tick === 1'b1) n = c;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL pause_resume: tick after %0d clocks expected 2", n);
    end
  endtask

  task automatic test_mode_change();
    bit found = 0;
    do_reset(2'd0);
    step_div = 1; run = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle();
      if (m_k >= 3 && m_cnt == 1) found = 1;
    end
    mode = 2'd1;
    cycle();
    checks++;
    if (!found || {tick, pos_idx, led} !== {1'b0, IWB'(0), W'(1)}) begin
      errors++;
      $display("FAIL mode_change: got tick=%b idx=%0d led=%h expected 0 0 01 (setup=%0d)", tick, pos_idx, led, found);
    end
    for (int c = 0; c < 2; c++) begin
      cycle();
      checks++;
      if ({tick, dir, pos_idx, led} !== exp_vec()) begin
        errors++;
        $display("FAIL mode_change_after c=%0d: got %h expected %h", c, {tick, dir, pos_idx, led}, exp_vec());
      end
    end
  endtask

  task automatic test_step_shrink();
    bit found = 0;
    do_reset(2'd0);
    step_div = 9; run = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      cycle();
      if (m_cnt == 5) found = 1;
    end
    step_div = 1;
    cycle();
    checks++;
    if (!found || tick !== 1'b1) begin
      errors++;
      $display("FAIL step_shrink: got tick=%b expected 1 (setup=%0d)", tick, found);
    end
  endtask

  task automatic test_rst_mid();
    bit found = 0;
    do_reset(2'd0);
    step_div = 0; run = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle();
      if (head_idx(m_mode, m_k) == 5 && exp_dir(m_mode, m_k)) found = 1;
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (!found || {tick, dir, led} !== {1'b0, 1'b0, W'(1)}) begin
      errors++;
      $display("FAIL rst_mid: got tick=%b dir=%b led=%h expected 0 0 01 (setup=%0d)", tick, dir, led, found);
    end
  endtask

  task automatic test_trail();
    int n0 = 0, n1 = 0, n2 = 0, other = 0, not4 = 0;
    bit found = 0;
    do_reset(2'd0);
    step_div = 15; run = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      cycle();
      if (m_tick && m_k == 2) found = 1;
    end
    for (int s = 0; s < 16; s++) begin
      if (s > 0) cycle();
      n0 += int'(led[0]); n1 += int'(led[1]); n2 += int'(led[2]);
      if (led[W-1:3] !== '0) other++;
      if (led !== W'(8'h04)) not4++;
    end
    checks++;
`ifdef LED_SCANNER_TRAIL_EN
    if (!found || n2 != 16 || n1 != 8 || n0 != 4 || other != 0) begin
      errors++;
      $display("FAIL trail_duty: got bit2=%0d bit1=%0d bit0=%0d upper=%0d expected 16 8 4 0", n2, n1, n0, other);
    end
`else
    if (!found || not4 != 0) begin
      errors++;
      $display("FAIL trail_off: %0d of 16 samples differ from 04 (bits %0d %0d %0d %0d)", not4, n2, n1, n0, other);
    end
`endif
  endtask

  task automatic test_random();
    do_reset(2'd0);
    run = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) run = ~run;
      if ($urandom_range(0, 24) == 0) step_div = DW'($urandom_range(0, 4));
      rst = ($urandom_range(0, 199) == 0);
      cycle();
      checks++;
      if ({tick, dir, pos_idx, led} !== exp_vec()) begin
        errors++;
        $display("FAIL random c=%0d mode=%0d: got %h expected %h", c, m_mode, {tick, dir, pos_idx, led}, exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_bounce();
    test_rotate();
    test_bar();
    test_run_pause();
    test_mode_change();
    test_step_shrink();
    test_rst_mid();
    test_trail();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
